// File: rtl/codif_bin_dec_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : codif_pkg                                                      |
// | Shared definitions for the sequential binary-to-BCD converter:           |
// | FSM state encoding and BCD digit width.                                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package codif_pkg;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVIERTE = 2'd1,
        FIN       = 2'd2
    } estado_t;

endpackage : codif_pkg
`default_nettype wire

// File: rtl/codif_bin_dec_seq_ajuste_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ajuste_bcd                                                     |
// | Combinational add-3 cell of the double-dabble algorithm: a digit of 5 or |
// | more gets +3 so that the following left shift carries correctly into     |
// | the next decimal digit.                                                  |
// | Ports   : entrada [BCD_W-1:0] digit before adjust                        |
// |           salida  [BCD_W-1:0] adjusted digit                             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ajuste_bcd
    import codif_pkg::*;
(
    input  logic [BCD_W-1:0] entrada,
    output logic [BCD_W-1:0] salida
);

    assign salida = (entrada >= BCD_W'(5)) ? (entrada + BCD_W'(3)) : entrada;

endmodule : ajuste_bcd
`default_nettype wire

// File: rtl/codif_bin_dec_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : codif_bin_dec_seq                                              |
// | Sequential binary-to-BCD converter (shift-add-3, one bit per clock)      |
// | with start/done handshake, held result and overflow flag.                |
// | Ports   : clk       system clock, rising edge                            |
// |           rst_n     asynchronous active-low reset                        |
// |           inicio    start request (taken when not converting)            |
// |           numero    [ANCHO-1:0] unsigned binary input                    |
// |           ocupado   conversion in progress                               |
// |           valido    one-cycle pulse, new result on bcd/desborde          |
// |           bcd       [4*DIGITOS-1:0] result, digit 0 = units              |
// |           desborde  numero >= 10**DIGITOS (bcd truncated)                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module codif_bin_dec_seq
    import codif_pkg::*;
#(
    parameter int ANCHO   = 16,
    parameter int DIGITOS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inicio,
    input  logic [ANCHO-1:0]         numero,
    output logic                     ocupado,
    output logic                     valido,
    output logic [BCD_W*DIGITOS-1:0] bcd,
    output logic                     desborde
);

    localparam int               CNT_W       = $clog2(ANCHO + 1);
    localparam int               ACC_W       = BCD_W * DIGITOS;
    localparam int               REG_W       = ACC_W + ANCHO;
    localparam logic [CNT_W-1:0] CNT_CARGA   = CNT_W'(ANCHO);
    localparam logic [CNT_W-1:0] CNT_UNO     = CNT_W'(1);

    estado_t            estado_q, estado_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ANCHO-1:0]   sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               desborde_q, desborde_d;
    logic               valido_q, valido_d;
    logic               ocupado_q, ocupado_d;

    logic [ACC_W-1:0]   acc_adj;
    logic [REG_W-1:0]   desplazado;
    logic               ovf_sig;

    for (genvar k = 0; k < DIGITOS; k++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .entrada (acc_q[BCD_W*k +: BCD_W]),
            .salida  (acc_adj[BCD_W*k +: BCD_W])
        );
    end

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        desborde_d = desborde_q;
        valido_d   = 1'b0;

        // The top adjusted bit leaves the accumulator on the shift; keeping
        // it only as a sticky flag yields numero mod 10**DIGITOS in bcd.
        desplazado = {acc_adj[ACC_W-2:0], sh_q, 1'b0};
        ovf_sig    = ovf_q | acc_adj[ACC_W-1];

        case (estado_q)
            // FIN also takes a new request so that a held inicio converts
            // back-to-back at one result every ANCHO+1 cycles.
            REPOSO, FIN: begin
                if (inicio) begin
                    sh_d     = numero;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    cnt_d    = CNT_CARGA;
                    estado_d = CONVIERTE;
                end else begin
                    estado_d = REPOSO;
                end
            end
            CONVIERTE: begin
                acc_d = desplazado[REG_W-1:ANCHO];
                sh_d  = desplazado[ANCHO-1:0];
                ovf_d = ovf_sig;
                cnt_d = cnt_q - CNT_UNO;
                if (cnt_q == CNT_UNO) begin
                    bcd_d      = desplazado[REG_W-1:ANCHO];
                    desborde_d = ovf_sig;
                    valido_d   = 1'b1;
                    estado_d   = FIN;
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        ocupado_d = (estado_d != REPOSO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= REPOSO;
            cnt_q      <= '0;
            sh_q       <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            desborde_q <= 1'b0;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            desborde_q <= desborde_d;
            valido_q   <= valido_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign ocupado  = ocupado_q;
    assign valido   = valido_q;
    assign bcd      = bcd_q;
    assign desborde = desborde_q;

endmodule : codif_bin_dec_seq
`default_nettype wire

// File: tb/tb_codif_bin_dec_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_codif_bin_dec_seq                                           |
// | Scoreboard bench for codif_bin_dec_seq: defaults (16/4) plus 8/3 and     |
// | 10/2 parameter sets, reference computed with decimal arithmetic.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_codif_bin_dec_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ini_a, ocu_a, val_a, des_a;
    logic [15:0] num_a, bcd_a;
    logic        ini_b, ocu_b, val_b, des_b;
    logic [7:0]  num_b;
    logic [11:0] bcd_b;
    logic        ini_c, ocu_c, val_c, des_c;
    logic [9:0]  num_c;
    logic [7:0]  bcd_c;

    codif_bin_dec_seq dut_a (
        .clk(clk), .rst_n(rst_n), .inicio(ini_a), .numero(num_a),
        .ocupado(ocu_a), .valido(val_a), .bcd(bcd_a), .desborde(des_a)
    );
    codif_bin_dec_seq #(.ANCHO(8), .DIGITOS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .inicio(ini_b), .numero(num_b),
        .ocupado(ocu_b), .valido(val_b), .bcd(bcd_b), .desborde(des_b)
    );
    codif_bin_dec_seq #(.ANCHO(10), .DIGITOS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .inicio(ini_c), .numero(num_c),
        .ocupado(ocu_c), .valido(val_c), .bcd(bcd_c), .desborde(des_c)
    );

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] bcd;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    // Expected busy window of dut_a, in edge numbers: [busy_lo, libre_a).
    int libre_a = 0;
    int busy_lo = 0;
    int libre_b = 0;
    int libre_c = 0;

    function automatic exp_t modelo(input longint unsigned v, input int dig, input int due);
        exp_t            e;
        longint unsigned p;
        longint unsigned r;
        p = 1;
        for (int i = 0; i < dig; i++) p = p * 10;
        e.ovf = (v >= p);
        r     = v % p;
        e.bcd = '0;
        for (int k = 0; k < dig; k++) begin
            e.bcd[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.due = due;
        return e;
    endfunction

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nombre, act, req, edge_n);
        end
    endtask

    // Record a request that reaches edge c on dut_a; accepted only when free.
    task automatic note_a(input logic [15:0] v, input int c);
        if (c >= libre_a) begin
            q_a.push_back(modelo(64'(v), 4, c + 16));
            if (c != libre_a) busy_lo = c;
            libre_a = c + 17;
        end
    endtask

    // All drive tasks are entered at a negedge and return at a negedge.
    task automatic pulse_a(input logic [15:0] v);
        ini_a = 1'b1;
        num_a = v;
        note_a(v, edge_n + 1);
        @(negedge clk);
        ini_a = 1'b0;
    endtask

    task automatic wait_free_a();
        while (edge_n + 1 < libre_a) @(negedge clk);
    endtask

    task automatic wait_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic conv_b(input logic [7:0] v);
        ini_b = 1'b1;
        num_b = v;
        if (edge_n + 1 >= libre_b) begin
            q_b.push_back(modelo(64'(v), 3, edge_n + 1 + 8));
            libre_b = edge_n + 1 + 9;
        end
        @(negedge clk);
        ini_b = 1'b0;
        while (edge_n + 1 < libre_b) @(negedge clk);
    endtask

    task automatic conv_c(input logic [9:0] v);
        ini_c = 1'b1;
        num_c = v;
        if (edge_n + 1 >= libre_c) begin
            q_c.push_back(modelo(64'(v), 2, edge_n + 1 + 10));
            libre_c = edge_n + 1 + 11;
        end
        @(negedge clk);
        ini_c = 1'b0;
        while (edge_n + 1 < libre_c) @(negedge clk);
    endtask

    // Monitors: compare whenever a DUT presents valido.
    always @(negedge clk) begin
        chk("ocupado_a", 64'(ocu_a), 64'(edge_n >= busy_lo && edge_n < libre_a));
        if (val_a) begin
            if (q_a.size() == 0) begin
                chk("valido_a_unexpected", 64'(val_a), 64'(0));
            end else begin
                e_a = q_a.pop_front();
                chk("bcd_a", 64'(bcd_a), 64'(e_a.bcd[15:0]));
                chk("desborde_a", 64'(des_a), 64'(e_a.ovf));
                chk("latency_a", 64'(edge_n), 64'(e_a.due));
            end
        end
        if (q_a.size() > 0 && edge_n > q_a[0].due) begin
            chk("valido_a_missing", 64'(val_a), 64'(1));
            void'(q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (val_b) begin
            if (q_b.size() == 0) begin
                chk("valido_b_unexpected", 64'(val_b), 64'(0));
            end else begin
                e_b = q_b.pop_front();
                chk("bcd_b", 64'(bcd_b), 64'(e_b.bcd[11:0]));
                chk("desborde_b", 64'(des_b), 64'(e_b.ovf));
                chk("latency_b", 64'(edge_n), 64'(e_b.due));
            end
        end
        if (q_b.size() > 0 && edge_n > q_b[0].due) begin
            chk("valido_b_missing", 64'(val_b), 64'(1));
            void'(q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (val_c) begin
            if (q_c.size() == 0) begin
                chk("valido_c_unexpected", 64'(val_c), 64'(0));
            end else begin
                e_c = q_c.pop_front();
                chk("bcd_c", 64'(bcd_c), 64'(e_c.bcd[7:0]));
                chk("desborde_c", 64'(des_c), 64'(e_c.ovf));
                chk("latency_c", 64'(edge_n), 64'(e_c.due));
            end
        end
        if (q_c.size() > 0 && edge_n > q_c[0].due) begin
            chk("valido_c_missing", 64'(val_c), 64'(1));
            void'(q_c.pop_front());
        end
    end

    initial begin
        int c;
        logic [15:0] basicos [8];
        basicos = '{16'd99, 16'd500, 16'd16, 16'd100, 16'd0, 16'd9999, 16'd10000, 16'd65535};

        rst_n = 1'b0;
        ini_a = 1'b0; num_a = '0;
        ini_b = 1'b0; num_b = '0;
        ini_c = 1'b0; num_c = '0;
        repeat (3) @(negedge clk);
        chk("reset_bcd_a", 64'(bcd_a), 64'(0));
        chk("reset_flags_a", 64'({ocu_a, val_a, des_a}), 64'(0));
        chk("reset_b", 64'({bcd_b, ocu_b, val_b, des_b}), 64'(0));
        chk("reset_c", 64'({bcd_c, ocu_c, val_c, des_c}), 64'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Basic conversions and boundaries, one pulse each.
        foreach (basicos[i]) begin
            pulse_a(basicos[i]);
            wait_free_a();
        end

        // Requests during a conversion are dropped.
        c = edge_n + 1;
        pulse_a(16'd1234);
        wait_to(c + 4);
        pulse_a(16'd42);
        wait_to(c + 15);
        pulse_a(16'd42);
        wait_free_a();
        repeat (3) @(negedge clk);

        // Held request: back-to-back conversions every 17 cycles.
        ini_a = 1'b1;
        num_a = 16'd7;
        repeat (3 * 17) begin
            note_a(16'd7, edge_n + 1);
            @(negedge clk);
        end
        ini_a = 1'b0;
        wait_free_a();
        repeat (2) @(negedge clk);

        // Input changes after capture do not affect the result.
        c = edge_n + 1;
        pulse_a(16'd321);
        wait_to(c + 1);
        num_a = 16'd999;
        wait_free_a();
        repeat (2) @(negedge clk);

        // Reset mid-conversion aborts with outputs at zero.
        c = edge_n + 1;
        pulse_a(16'd4321);
        wait_to(c + 8);
        #2 rst_n = 1'b0;
        q_a.delete();
        libre_a = 0;
        busy_lo = 0;
        #1;
        chk("abort_bcd_a", 64'(bcd_a), 64'(0));
        chk("abort_flags_a", 64'({ocu_a, val_a, des_a}), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse_a(16'd55);
        wait_free_a();
        repeat (2) @(negedge clk);

        // Random traffic, including requests that land while busy.
        repeat (25) begin
            pulse_a(16'($urandom_range(0, 65535)));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_free_a();

        // Other parameter sets.
        conv_b(8'd255);
        conv_c(10'd1023);
        repeat (6) begin
            conv_b(8'($urandom_range(0, 255)));
            conv_c(10'($urandom_range(0, 1023)));
        end

        repeat (30) @(negedge clk);
        chk("pending_results", 64'(q_a.size() + q_b.size() + q_c.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_codif_bin_dec_seq
`default_nettype wire
